// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int MAX_WIDTH = 64;

    // Counter must hold 0..WIDTH so the last bit index is always representable.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
interface serial_adder_if #(parameter int WIDTH = 8);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             busy;

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, carry, busy
    );

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, carry, busy
    );

endinterface

// File: rtl/serial_adder_full_adder_cell.sv
// Single-bit full adder built from two half adders; the one arithmetic cell of the serial datapath.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s1_s;
    logic c1_s;
    logic c2_s;

    half_adder u_ha0 (.x(a),    .y(b),  .s(s1_s), .c(c1_s));
    half_adder u_ha1 (.x(s1_s), .y(ci), .s(s),    .c(c2_s));

    assign co = c1_s | c2_s;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell and a carry flop resolve one bit per clock, LSB first.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q,     state_d;
    logic [WIDTH-1:0] a_sr_q,      a_sr_d;
    logic [WIDTH-1:0] b_sr_q,      b_sr_d;
    logic [WIDTH-1:0] sum_sr_q,    sum_sr_d;
    logic             c_q,         c_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q,      busy_d;

    logic             fa_s_s;
    logic             fa_co_s;
    logic [WIDTH-1:0] sum_shift_s;

    full_adder_cell u_fa (
        .a  (a_sr_q[0]),
        .b  (b_sr_q[0]),
        .ci (c_q),
        .s  (fa_s_s),
        .co (fa_co_s)
    );

    // New sum bit enters at the top so that after WIDTH shifts the first bit sits at bit 0.
    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign sum_shift_s = fa_s_s;
        end else begin : g_shift_wn
            assign sum_shift_s = {fa_s_s, sum_sr_q[WIDTH-1:1]};
        end
    endgenerate

    // Next-state and next-output computation for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        a_sr_d      = a_sr_q;
        b_sr_d      = b_sr_q;
        sum_sr_d    = sum_sr_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_sr_d     = bus.a;
                    b_sr_d     = bus.b;
                    c_d        = bus.cin;
                    cnt_d      = '0;
                    sum_sr_d   = '0;
                    state_d    = ST_RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_RUN: begin
                sum_sr_d = sum_shift_s;
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                c_d      = fa_co_s;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d     = ST_DONE;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
                end else begin
                    state_d     = ST_RUN;
                end
            end
            ST_DONE: begin
                // A simultaneous in_valid is deliberately not looked at here; acceptance waits for IDLE.
                if (bus.out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end else begin
                    state_d     = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            sum_sr_q    <= '0;
            c_q         <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            sum_sr_q    <= sum_sr_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.sum       = sum_sr_q;
    assign bus.carry     = c_q;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder. It accepts two operands plus carry-in over a valid/ready handshake.
- It then resolves one bit per clock, LSB first, through a single full-adder cell and a carry register.
- It presents the N-bit sum and carry-out over a valid/ready handshake.
- It is the sequential consumer of the team's single-bit adder cells. It trades area for latency wherever wide adds are infrequent.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..64.

Ports:
- clk  in  1  single clock, rising-edge active
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands a, b, cin valid this cycle
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in
- out_valid  out  1  sum/carry valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  a + b + cin, low WIDTH bits
- carry  out  1  carry-out of the WIDTH-bit add
- busy  out  1  high in RUN state

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset rst_n is asynchronous, active-low.
  - All state is cleared immediately on rst_n low, independent of clk.
- Reset values:
  - state=IDLE; in_ready=1 (derived from state); out_valid=0; busy=0.
  - sum=0; carry=0; internal shift registers and bit counter = 0.
- States:
  - IDLE: in_ready=1. If in_valid is high at a clock edge:
    - capture a, b into operand shift registers;
    - carry register ← cin; bit counter ← 0; sum register ← 0;
    - next state = RUN.
  - RUN: in_ready=0, busy=1. On each edge:
    - s = a_sr[0] ^ b_sr[0] ^ c; c_next = majority(a_sr[0], b_sr[0], c);
    - sum_sr ← {s, sum_sr[WIDTH-1:1]};
    - a_sr, b_sr shift right by 1 (zero fill); counter++.
    - On the edge where counter == WIDTH-1, next state = DONE.
  - DONE: out_valid=1, in_ready=0. sum = sum_sr and carry = carry register, both held stable.
    - On an edge with out_ready=1, next state = IDLE.
- Latency and throughput:
  - out_valid rises exactly WIDTH edges after the accepting edge.
  - Minimum initiation interval is WIDTH+2 cycles. Input acceptance does not overlap the result presentation.
- Handshake rules:
  - in_valid is ignored outside IDLE. No acceptance occurs and no state changes.
  - While out_valid=1 and out_ready=0, sum, carry and out_valid are held indefinitely.
  - out_ready is ignored outside DONE.
  - in_valid and out_ready arriving high together in DONE: only the output handshake occurs. The new operands are accepted no earlier than the following edge in IDLE.
- Width rules:
  - Bit counter width = $clog2(WIDTH+1).
  - Result equals (a + b + cin) mod 2^WIDTH; carry = bit WIDTH of the full sum.
- WIDTH=1: RUN lasts one edge, and out_valid rises one edge after acceptance.
- Reset mid-operation: rst_n low in RUN or DONE aborts the operation and returns all outputs to reset values. The partial result is never emitted.
- Between the DONE→IDLE edge and the next completed operation, the sum and carry outputs are don't-care. They are registered and not cleared.

Decomposition:
- Shared package:
  - state encoding typedef (IDLE, RUN, DONE; 2 bits);
  - localparam for counter width derivation.
- Natural sub-module full_adder_cell:
  - combinational 1-bit full adder built from two half_adder instances plus OR for carry;
  - instantiated once in the RUN datapath.
- FSM, counter and shift registers live in serial_adder.

Test Plan:
- WIDTH=8, a=0x3C, b=0x0F, cin=0, out_ready=1 -> out_valid exactly 8 edges after acceptance, sum=0x4B, carry=0, in_ready returns 1 one cycle after the output handshake.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, carry=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, carry=1.
- Backpressure: a=0x12, b=0x34, out_ready held 0 for 5 cycles after out_valid -> sum=0x46, carry=0 stable and out_valid high throughout; handshake on cycle 6 -> IDLE.
- in_valid pulsed with a=0xAA during RUN -> ignored; in_ready stays 0 and the result matches the originally accepted operands.
- rst_n asserted at RUN bit 3 of 0x80+0x80 -> out_valid=0, sum=0, carry=0, in_ready=1 immediately; the next op, 0x01+0x01, yields sum=0x02, carry=0.
- WIDTH=1 build: a=1, b=1, cin=1 -> out_valid 1 edge after acceptance, sum=1, carry=1; random self-checking sweep of 1000 ops at WIDTH=8 against a+b+cin.
